// File: rtl/timer_responder_if.sv
// Data-bus port bundle between the M stage and the memory-mapped timer.
interface timer_responder_if;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic        hit;
    logic [31:0] rdata;
    logic        irq;

    modport master (output addr, we, byteen, wdata, input hit, rdata, irq);
    modport slave  (input addr, we, byteen, wdata, output hit, rdata, irq);
endinterface

// File: rtl/timer_responder.sv
// Countdown timer on a 16-byte data-bus window: CTRL/PRESET/COUNT registers,
// four-state countdown FSM and a level interrupt toward the CPU.
module timer_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic               clk,
    input  logic               reset,
    timer_responder_if.slave   bus
);
    localparam int unsigned DW    = 32;
    localparam int unsigned CW    = 4;
    localparam int unsigned LANES = 4;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_ctrl, w_ctrl_nxt;
    logic [DW-1:0]   r_preset, w_preset_nxt;
    logic [DW-1:0]   r_count, w_count_nxt;
    logic            r_flag, w_flag_nxt;

    logic            w_hit;
    logic            w_wr;
    logic [1:0]      w_sel;
    logic            w_en;
    logic            w_im;
    logic            w_autoreload;
    logic            w_set_flag;
    logic            w_clr_flag;
    logic [DW-1:0]   w_rdata;
    logic            w_unused;

    assign w_hit        = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign w_wr         = bus.we & w_hit;
    assign w_sel        = bus.addr[3:2];
    assign w_en         = r_ctrl[0];
    assign w_im         = r_ctrl[3];
    assign w_autoreload = (r_ctrl[2:1] == 2'b01);
    assign w_unused     = ^bus.addr[1:0];

    // Next-state, register-update and flag logic
    always_comb begin
        w_state_nxt  = r_state;
        w_ctrl_nxt   = r_ctrl;
        w_preset_nxt = r_preset;
        w_count_nxt  = r_count;
        w_flag_nxt   = r_flag;
        w_set_flag   = 1'b0;
        w_clr_flag   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_en) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_count_nxt = r_preset;
                w_state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!w_en) begin
                    w_state_nxt = S_IDLE;
                end else if (r_count > DW'(1)) begin
                    w_count_nxt = r_count - DW'(1);
                end else begin
                    w_count_nxt = '0;
                    w_set_flag  = 1'b1;
                    w_state_nxt = S_INT;
                end
            end
            S_INT: begin
                if (w_autoreload) w_clr_flag = 1'b1;
                else              w_ctrl_nxt[0] = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // CPU CTRL write overrides the one-shot EN clear
        if (w_wr && (w_sel == REG_CTRL) && bus.byteen[0])
            w_ctrl_nxt = bus.wdata[CW-1:0];

        for (int i = 0; i < LANES; i++) begin
            if (w_wr && (w_sel == REG_PRESET) && bus.byteen[i])
                w_preset_nxt[8*i +: 8] = bus.wdata[8*i +: 8];
        end

        if (w_wr && ((w_sel == REG_CTRL) || (w_sel == REG_PRESET)))
            w_clr_flag = 1'b1;

        // Set has priority so a concurrent write never drops an interrupt
        if (w_set_flag)      w_flag_nxt = 1'b1;
        else if (w_clr_flag) w_flag_nxt = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ctrl   <= '0;
            r_preset <= '0;
            r_count  <= '0;
            r_flag   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ctrl   <= w_ctrl_nxt;
            r_preset <= w_preset_nxt;
            r_count  <= w_count_nxt;
            r_flag   <= w_flag_nxt;
        end
    end

    // Same-cycle read mux so the M stage never stalls
    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (w_sel)
                REG_CTRL:   w_rdata = DW'(r_ctrl);
                REG_PRESET: w_rdata = r_preset;
                REG_COUNT:  w_rdata = r_count;
                default:    w_rdata = '0;
            endcase
        end
    end

    assign bus.hit   = w_hit;
    assign bus.rdata = w_rdata;
    assign bus.irq   = r_flag & w_im;
endmodule

// File: tb/tb_timer_responder.sv
// Directed bench for timer_responder with hand-computed expected values.
module tb_timer_responder;
    localparam logic [31:0] BASE = 32'h0000_7F00;
    localparam logic [31:0] OFF_CTRL   = 32'h0;
    localparam logic [31:0] OFF_PRESET = 32'h4;
    localparam logic [31:0] OFF_COUNT  = 32'h8;
    localparam logic [31:0] OFF_RSVD   = 32'hC;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    timer_responder_if bus();

    timer_responder #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Store lands on the next rising edge
    task automatic wr(input logic [31:0] off, input logic [31:0] data, input logic [3:0] be);
        bus.addr   = BASE + off;
        bus.wdata  = data;
        bus.byteen = be;
        bus.we     = 1'b1;
        tick();
        bus.we     = 1'b0;
        bus.byteen = 4'h0;
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] data);
        bus.addr = BASE + off;
        #1;
        data = bus.rdata;
    endtask

    logic [31:0] v;
    logic [31:0] exp_cnt [10];
    logic        exp_irq [10];

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        bus.addr   = BASE;
        bus.we     = 1'b0;
        bus.byteen = 4'h0;
        bus.wdata  = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state and decode
        rd(OFF_CTRL, v);   check("rst_ctrl", v, 0);
        check("rst_hit", 32'(bus.hit), 1);
        rd(OFF_PRESET, v); check("rst_preset", v, 0);
        rd(OFF_COUNT, v);  check("rst_count", v, 0);
        rd(OFF_RSVD, v);   check("rst_rsvd", v, 0);
        check("rst_irq", 32'(bus.irq), 0);
        rd(32'h10, v);     check("miss_rdata", v, 0);
        check("miss_hit", 32'(bus.hit), 0);

        // One-shot countdown from 5
        wr(OFF_PRESET, 5, 4'hF);
        rd(OFF_PRESET, v); check("preset_rb", v, 5);
        wr(OFF_CTRL, 32'h9, 4'hF);            // edge 0
        tick();                               // edge 1
        for (int i = 0; i < 5; i++) begin
            tick();                           // edges 2..6
            rd(OFF_COUNT, v); check("os_count", v, 32'(5 - i));
            check("os_irq_low", 32'(bus.irq), 0);
        end
        tick();                               // edge 7
        rd(OFF_COUNT, v); check("os_count_end", v, 0);
        check("os_irq_set", 32'(bus.irq), 1);
        tick();
        rd(OFF_CTRL, v);  check("os_ctrl_en_clr", v, 32'h8);
        tick();
        tick();
        check("os_irq_hold", 32'(bus.irq), 1);
        wr(OFF_PRESET, 5, 4'hF);
        check("os_irq_clr", 32'(bus.irq), 0);

        // Auto-reload with PRESET=2: 5-cycle period
        wr(OFF_PRESET, 2, 4'hF);
        exp_cnt = '{0, 2, 1, 0, 0, 0, 2, 1, 0, 0};
        exp_irq = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        wr(OFF_CTRL, 32'hB, 4'hF);            // edge 0
        bus.addr = BASE + OFF_COUNT;
        for (int k = 0; k < 10; k++) begin
            tick();                           // edges 1..10
            check("ar_count", bus.rdata, exp_cnt[k]);
            check("ar_irq", 32'(bus.irq), 32'(exp_irq[k]));
        end
        wr(OFF_CTRL, 0, 4'hF);
        tick();
        tick();

        // Byte-lane writes
        wr(OFF_PRESET, 0, 4'hF);
        wr(OFF_PRESET, 32'hAABBCCDD, 4'b0010);
        rd(OFF_PRESET, v); check("lane1_preset", v, 32'h0000CC00);
        wr(OFF_CTRL, 32'h8, 4'hF);
        wr(OFF_CTRL, 32'hFFFFFFF7, 4'b1110);
        rd(OFF_CTRL, v);   check("ctrl_upper_lanes", v, 32'h8);
        wr(OFF_CTRL, 32'hF8, 4'b0001);
        rd(OFF_CTRL, v);   check("ctrl_bits_7_4", v, 32'h8);

        // Stop mid-count: COUNT freezes
        wr(OFF_PRESET, 100, 4'hF);
        wr(OFF_CTRL, 32'h1, 4'hF);            // edge 0
        tick();
        tick();                               // edge 2
        rd(OFF_COUNT, v); check("stop_count100", v, 100);
        wr(OFF_CTRL, 0, 4'hF);                // edge 3
        rd(OFF_COUNT, v); check("stop_count99", v, 99);
        tick();
        tick();
        tick();
        rd(OFF_COUNT, v); check("stop_frozen", v, 99);

        // Restart and assert async reset mid-count
        wr(OFF_CTRL, 32'h9, 4'hF);            // edge 0
        tick();
        tick();
        tick();
        tick();                               // edge 4
        rd(OFF_COUNT, v); check("restart_count", v, 98);
        reset = 1'b1;
        rd(OFF_COUNT, v);  check("arst_count", v, 0);
        rd(OFF_CTRL, v);   check("arst_ctrl", v, 0);
        rd(OFF_PRESET, v); check("arst_preset", v, 0);
        check("arst_irq", 32'(bus.irq), 0);
        tick();
        reset = 1'b0;
        tick();

        // PRESET=0 and CTRL write colliding with flag set
        wr(OFF_PRESET, 0, 4'hF);
        wr(OFF_CTRL, 32'h9, 4'hF);            // edge 0
        tick();
        tick();                               // edge 2
        check("p0_irq_before", 32'(bus.irq), 0);
        wr(OFF_CTRL, 32'h9, 4'hF);            // edge 3: INT reached
        check("p0_irq_set_wins", 32'(bus.irq), 1);
        rd(OFF_COUNT, v); check("p0_count", v, 0);
        tick();
        check("p0_irq_hold", 32'(bus.irq), 1);
        rd(OFF_CTRL, v);  check("p0_ctrl", v, 32'h8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
